wdt_mmio: RTL and testbench
===========================

Name: wdt_mmio

Overview:
- Memory-mapped watchdog timer peripheral attached to the Memory stage load/store path of the RV32I pipeline.
- Produces the `wdt_irq` and `wdt_reset` signals that the pipeline top exposes and the system bench monitors.
- Software enables it, then feeds it by writing a key to the KICK register.
- If software stops feeding it, the block raises an interrupt, waits a grace window, then pulses reset.

Parameters:
- BASE_ADDR, 32'h0000_0100: base byte address of the 5-word register window.
- DEFAULT_TIMEOUT, 1024: reset value of the LOAD register (cycles).
- GRACE_CYCLES, 64: cycles between `wdt_irq` assertion and reset escalation.
- RST_PULSE_CYCLES, 8: width of the `wdt_reset` pulse.
- KICK_KEY, 32'hC0DE_FEED: only value accepted as a valid feed.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mem_we  in  1  store strobe from the Memory stage.
- mem_re  in  1  load strobe from the Memory stage.
- mem_addr  in  32  byte address; word-aligned accesses only.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; combinational; 0 when not selected.
- wdt_irq  out  1  level interrupt.
- wdt_reset  out  1  processor reset request pulse.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x00 CTRL RW: [0] EN, [1] IRQ_EN, [2] LOCK (see Optional Feature).
  - 0x04 LOAD RW: timeout in cycles.
  - 0x08 KICK WO: reads return 0.
  - 0x0C COUNT RO: live counter.
  - 0x10 STATUS: [0] IRQF, [1] RSTF; write-1-to-clear.
- Accesses outside the window are ignored. Unused register bits read 0.
- Reset (`rst`):
  - CTRL=0, LOAD=DEFAULT_TIMEOUT, COUNT=DEFAULT_TIMEOUT, STATUS=0.
  - State = IDLE, `wdt_irq`=0, `wdt_reset`=0.
  - `rst` mid-operation in any state returns the block to these values on the next edge.
- A write of 0 to LOAD is ignored; LOAD keeps its old value.
- A LOAD write during COUNT affects only the next reload, not the running count.
- FSM states and transitions:
  - IDLE:
    - COUNT is held equal to LOAD.
    - A CTRL write with EN=1 moves to COUNT; COUNT=LOAD after that edge.
  - COUNT:
    - COUNT decrements by 1 per cycle.
    - A valid kick (KICK write == KICK_KEY) reloads COUNT=LOAD on the next edge.
    - On the edge where COUNT==0 with no kick:
      - If IRQ_EN=1: set IRQF, load the grace counter with GRACE_CYCLES, go to GRACE.
      - Otherwise go to RESET.
  - GRACE:
    - The grace counter decrements each cycle.
    - A valid kick returns to COUNT with COUNT=LOAD; IRQF stays set until software clears it.
    - Grace counter reaching 0 goes to RESET.
  - RESET:
    - `wdt_reset`=1 for exactly RST_PULSE_CYCLES cycles.
    - After the pulse: set RSTF, clear EN, COUNT=LOAD, go to IDLE.
    - The block is not cleared by its own `wdt_reset`; RSTF survives it.
- Any KICK write with a value other than KICK_KEY, in COUNT or GRACE, goes straight to RESET on the next edge.
- KICK writes in IDLE or RESET are ignored.
- A CTRL write with EN=0 in COUNT or GRACE goes to IDLE; IRQF is kept.
- CTRL writes during RESET are ignored.
- `wdt_irq` = IRQF & IRQ_EN, registered (no combinational path from the bus).
- Simultaneous events:
  - A valid kick on the same edge as COUNT==0 wins: reload, no IRQ.
  - A W1C of IRQF on the same edge IRQF is set: the set wins.
- Counters are 32-bit unsigned and never wrap below 0.

Optional Feature:
- Macro: WDT_LOCK_EN.
- Defined:
  - CTRL[2] LOCK is writable and sticky; once set, only `rst` clears it.
  - While LOCK=1, writes to CTRL and LOAD are ignored entirely, so EN cannot be cleared and LOAD cannot change.
  - KICK and STATUS writes are still honoured.
- Not defined: CTRL[2] reads 0 and writes to it have no effect.

Test Plan (bench overrides: DEFAULT_TIMEOUT=16, GRACE_CYCLES=8, RST_PULSE_CYCLES=4):
- Write CTRL=0x3 at edge E0, never kick -> COUNT reads 16 after E0 and 0 after E16; `wdt_irq` high after E17; `wdt_reset` high after E25 through E28; then STATUS=0x3 and CTRL.EN=0.
- Enable with LOAD=16, write KICK=0xC0DE_FEED every 10 cycles for 200 cycles -> `wdt_irq` and `wdt_reset` stay 0; COUNT never below 6.
- Enable, then write KICK=0x1234_5678 -> `wdt_reset` asserts on the next edge for 4 cycles; RSTF=1; `wdt_irq`=0.
- CTRL=0x3, let IRQ fire, kick during GRACE, write STATUS=0x1 -> state COUNT, COUNT=16, `wdt_irq` falls after the W1C edge, no reset.
- Valid kick on the exact edge COUNT==0; separately, LOAD=0 write -> no IRQ and COUNT=16 in the first case; LOAD still reads 16 in the second.
- WDT_LOCK_EN defined: CTRL=0x5, then write CTRL=0 -> EN stays 1 and expiry still occurs; after `rst`, CTRL=0.

Source files
------------

// File: rtl/wdt_mmio.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wdt_mmio - memory-mapped watchdog timer on the Memory-stage load/store path.
//
// Software enables the watchdog through CTRL and feeds it by writing KICK_KEY
// to KICK. A starved watchdog raises wdt_irq (when IRQ_EN is set), waits
// GRACE_CYCLES, then pulses wdt_reset for RST_PULSE_CYCLES cycles.
//
// Register window at BASE_ADDR (word-aligned only, anything else ignored):
//   0x00 CTRL   RW  [0] EN, [1] IRQ_EN, [2] LOCK
//   0x04 LOAD   RW  timeout in cycles (a write of 0 is dropped)
//   0x08 KICK   WO  reads 0
//   0x0C COUNT  RO  live counter
//   0x10 STATUS W1C [0] IRQF, [1] RSTF
//
// Optional feature: define WDT_LOCK_EN to make CTRL[2] a sticky lock that
// freezes CTRL and LOAD until rst. Without it CTRL[2] reads 0.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   mem_we     store strobe
//   mem_re     load strobe
//   mem_addr   byte address
//   mem_wdata  store data
//   mem_rdata  load data, combinational, 0 when not selected
//   wdt_irq    registered level interrupt (IRQF & IRQ_EN)
//   wdt_reset  registered processor reset request pulse
// -----------------------------------------------------------------------------
module wdt_mmio #(
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0100,
    parameter int unsigned DEFAULT_TIMEOUT  = 1024,
    parameter int unsigned GRACE_CYCLES     = 64,
    parameter int unsigned RST_PULSE_CYCLES = 8,
    parameter logic [31:0] KICK_KEY         = 32'hC0DE_FEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        wdt_irq,
    output logic        wdt_reset
);

    localparam logic [31:0] TIMEOUT_INIT = 32'(DEFAULT_TIMEOUT);
    localparam logic [31:0] GRACE_INIT   = 32'(GRACE_CYCLES);
    localparam logic [31:0] PULSE_INIT   = 32'(RST_PULSE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_GRACE, S_RESET} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        irq_en_q, irq_en_d;
    logic        irqf_q, irqf_d;
    logic        rstf_q, rstf_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic [31:0] grace_q, grace_d;
    logic [31:0] pulse_q, pulse_d;
    logic        lock_q;

    // Address decode: exact word matches, so misaligned or out-of-window
    // accesses select nothing.
    logic sel_ctrl, sel_load, sel_kick, sel_count, sel_status;
    assign sel_ctrl   = (mem_addr == BASE_ADDR);
    assign sel_load   = (mem_addr == BASE_ADDR + 32'h4);
    assign sel_kick   = (mem_addr == BASE_ADDR + 32'h8);
    assign sel_count  = (mem_addr == BASE_ADDR + 32'hC);
    assign sel_status = (mem_addr == BASE_ADDR + 32'h10);

    logic wr_ctrl, wr_load, wr_kick, wr_status;
    logic kick_good, kick_bad, ctrl_ok, load_ok;
    assign wr_ctrl   = mem_we & sel_ctrl;
    assign wr_load   = mem_we & sel_load;
    assign wr_kick   = mem_we & sel_kick;
    assign wr_status = mem_we & sel_status;
    assign kick_good = wr_kick & (mem_wdata == KICK_KEY);
    assign kick_bad  = wr_kick & (mem_wdata != KICK_KEY);
    // CTRL is frozen while the reset pulse is running or the lock is set.
    assign ctrl_ok   = wr_ctrl & (state_q != S_RESET) & ~lock_q;
    assign load_ok   = wr_load & (mem_wdata != 32'd0) & ~lock_q;

`ifdef WDT_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst)
            lock_q <= 1'b0;
        else if (wr_ctrl && state_q != S_RESET && mem_wdata[2])
            lock_q <= 1'b1;
    end
`else
    assign lock_q = 1'b0;
`endif

    always_comb begin
        // NOTE: every next-value starts as a copy of its register so no path
        // through this block can leave a signal unassigned and infer a latch.
        state_d  = state_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        irqf_d   = irqf_q;
        rstf_d   = rstf_q;
        load_d   = load_q;
        count_d  = count_q;
        grace_d  = grace_q;
        pulse_d  = pulse_q;

        if (load_ok)
            load_d = mem_wdata;
        // Clears are applied first so a hardware set later in this block wins.
        if (wr_status) begin
            if (mem_wdata[0]) irqf_d = 1'b0;
            if (mem_wdata[1]) rstf_d = 1'b0;
        end
        if (ctrl_ok) begin
            en_d     = mem_wdata[0];
            irq_en_d = mem_wdata[1];
        end

        unique case (state_q)
            S_IDLE: begin
                count_d = load_d;
                if (ctrl_ok && mem_wdata[0])
                    state_d = S_COUNT;
            end
            S_COUNT: begin
                if (ctrl_ok && !mem_wdata[0]) begin
                    state_d = S_IDLE;
                    count_d = load_q;
                end else if (kick_good) begin
                    count_d = load_q;
                end else if (kick_bad) begin
                    state_d = S_RESET;
                    pulse_d = PULSE_INIT;
                end else if (count_q == 32'd0) begin
                    if (irq_en_d) begin
                        irqf_d  = 1'b1;
                        grace_d = GRACE_INIT;
                        state_d = S_GRACE;
                    end else begin
                        state_d = S_RESET;
                        pulse_d = PULSE_INIT;
                    end
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            S_GRACE: begin
                if (ctrl_ok && !mem_wdata[0]) begin
                    state_d = S_IDLE;
                    count_d = load_q;
                end else if (kick_good) begin
                    state_d = S_COUNT;
                    count_d = load_q;
                end else if (kick_bad || grace_q <= 32'd1) begin
                    // The edge that would take the grace counter to 0 escalates.
                    state_d = S_RESET;
                    grace_d = 32'd0;
                    pulse_d = PULSE_INIT;
                end else begin
                    grace_d = grace_q - 32'd1;
                end
            end
            S_RESET: begin
                if (pulse_q <= 32'd1) begin
                    state_d = S_IDLE;
                    rstf_d  = 1'b1;
                    en_d    = 1'b0;
                    count_d = load_d;
                    pulse_d = 32'd0;
                end else begin
                    pulse_d = pulse_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            irqf_q    <= 1'b0;
            rstf_q    <= 1'b0;
            load_q    <= TIMEOUT_INIT;
            count_q   <= TIMEOUT_INIT;
            grace_q   <= 32'd0;
            pulse_q   <= 32'd0;
            wdt_irq   <= 1'b0;
            wdt_reset <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            irqf_q    <= irqf_d;
            rstf_q    <= rstf_d;
            load_q    <= load_d;
            count_q   <= count_d;
            grace_q   <= grace_d;
            pulse_q   <= pulse_d;
            wdt_irq   <= irqf_d & irq_en_d;
            wdt_reset <= (state_d == S_RESET);
        end
    end

    always_comb begin
        mem_rdata = 32'd0;
        if (mem_re) begin
            if (sel_ctrl)
                mem_rdata = {29'd0, lock_q, irq_en_q, en_q};
            else if (sel_load)
                mem_rdata = load_q;
            else if (sel_count)
                mem_rdata = count_q;
            else if (sel_status)
                mem_rdata = {30'd0, rstf_q, irqf_q};
        end
    end

endmodule

// File: tb/tb_wdt_mmio.sv
`timescale 1ns/1ps
// Self-checking bench for wdt_mmio with short timing parameters:
// DEFAULT_TIMEOUT=16, GRACE_CYCLES=8, RST_PULSE_CYCLES=4.
module tb_wdt_mmio;

    localparam logic [31:0] BASE     = 32'h0000_0100;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_LOAD   = BASE + 32'h4;
    localparam logic [31:0] A_KICK   = BASE + 32'h8;
    localparam logic [31:0] A_COUNT  = BASE + 32'hC;
    localparam logic [31:0] A_STATUS = BASE + 32'h10;
    localparam logic [31:0] KEY      = 32'hC0DE_FEED;
    localparam logic [31:0] BAD_KEY  = 32'h1234_5678;
    localparam int          TO = 16;
    localparam int          GR = 8;
    localparam int          PW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [31:0] mem_rdata;
    logic        wdt_irq;
    logic        wdt_reset;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wdt_mmio #(
        .BASE_ADDR(BASE),
        .DEFAULT_TIMEOUT(TO),
        .GRACE_CYCLES(GR),
        .RST_PULSE_CYCLES(PW),
        .KICK_KEY(KEY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .wdt_irq(wdt_irq),
        .wdt_reset(wdt_reset)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        tick();
        mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        mem_re = 1'b1; mem_addr = a;
        #1;
        d = mem_rdata;
        mem_re = 1'b0; mem_addr = 32'd0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(name, v, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_we = 1'b0; mem_re = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    // Time-stamped view: a counting window is described by the edge it was
    // (re)loaded on and the value loaded; grace and pulse windows by their
    // start edge. Values are derived from elapsed edges, not stepped counters.
    int          m_phase;   // 0 idle, 1 counting, 2 grace window, 3 reset pulse
    logic        m_en, m_irq_en, m_irqf, m_rstf, m_lock;
    logic [31:0] m_load, m_reload, m_frozen;
    longint      m_n, m_tref, m_tg, m_tr;

    function automatic logic [31:0] m_count();
        case (m_phase)
            0:       return m_load;
            1:       return m_reload - 32'(m_n - m_tref);
            2:       return 32'd0;
            default: return m_frozen;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        if (a == A_CTRL)   return {29'd0, m_lock, m_irq_en, m_en};
        if (a == A_LOAD)   return m_load;
        if (a == A_COUNT)  return m_count();
        if (a == A_STATUS) return {30'd0, m_rstf, m_irqf};
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_en = 0; m_irq_en = 0; m_irqf = 0; m_rstf = 0; m_lock = 0;
        m_load = 32'(TO); m_reload = 32'(TO); m_frozen = 0;
        m_n = 0; m_tref = 0; m_tg = 0; m_tr = 0;
    endtask

    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] cur;
        logic [31:0] old_load;
        logic ctrl_ok, good, bad;
        cur      = m_count();
        old_load = m_load;
        ctrl_ok  = we && a == A_CTRL && m_phase != 3 && !m_lock;
        good     = we && a == A_KICK && d == KEY;
        bad      = we && a == A_KICK && d != KEY;
        m_n++;
        if (we && a == A_LOAD && d != 0 && !m_lock) m_load = d;
        if (we && a == A_STATUS) begin
            if (d[0]) m_irqf = 0;
            if (d[1]) m_rstf = 0;
        end
        if (ctrl_ok) begin
            m_en = d[0]; m_irq_en = d[1];
`ifdef WDT_LOCK_EN
            if (d[2]) m_lock = 1;
`endif
        end
        case (m_phase)
            0: if (ctrl_ok && d[0]) begin m_phase = 1; m_reload = m_load; m_tref = m_n; end
            1: begin
                if (ctrl_ok && !d[0]) m_phase = 0;
                else if (good) begin m_reload = old_load; m_tref = m_n; end
                else if (bad) begin m_phase = 3; m_tr = m_n; m_frozen = cur; end
                else if (cur == 0) begin
                    if (m_irq_en) begin m_irqf = 1; m_phase = 2; m_tg = m_n; end
                    else begin m_phase = 3; m_tr = m_n; m_frozen = 0; end
                end
            end
            2: begin
                if (ctrl_ok && !d[0]) m_phase = 0;
                else if (good) begin m_phase = 1; m_reload = old_load; m_tref = m_n; end
                else if (bad || m_n - m_tg >= GR) begin m_phase = 3; m_tr = m_n; m_frozen = 0; end
            end
            default: if (m_n - m_tr >= PW) begin m_phase = 0; m_rstf = 1; m_en = 0; end
        endcase
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
        logic        exp_reset;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic we, input logic re, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.re = re; v.addr = a; v.wdata = d; v.exp_rdata = exp;
        v.exp_irq = 1'b0; v.exp_reset = 1'b0;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] min_cnt;
        logic        irq_seen, rst_seen;

        // Idle-state register behaviour, reset values, decode boundaries.
        add_vec(0, 1, A_CTRL,   0, 32'd0);
        add_vec(0, 1, A_LOAD,   0, 32'd16);
        add_vec(0, 1, A_COUNT,  0, 32'd16);
        add_vec(0, 1, A_STATUS, 0, 32'd0);
        add_vec(0, 1, A_KICK,   0, 32'd0);
        add_vec(1, 0, A_LOAD,   0, 32'd0);
        add_vec(0, 1, A_LOAD,   0, 32'd16);
        add_vec(1, 0, A_LOAD,   12, 32'd0);
        add_vec(0, 1, A_LOAD,   0, 32'd12);
        add_vec(0, 1, A_COUNT,  0, 32'd12);
        add_vec(1, 0, A_LOAD,   16, 32'd0);
        add_vec(1, 0, BASE + 32'h14, 32'hFFFF_FFFF, 32'd0);
        add_vec(0, 1, BASE + 32'h14, 0, 32'd0);
        add_vec(0, 1, BASE - 32'h4,  0, 32'd0);
        add_vec(0, 1, BASE + 32'h2,  0, 32'd0);
        add_vec(1, 0, A_KICK,   BAD_KEY, 32'd0);
        add_vec(1, 0, A_STATUS, 3, 32'd0);
        add_vec(0, 1, A_CTRL,   0, 32'd0);
        add_vec(0, 1, A_COUNT,  0, 32'd16);

        do_reset();
        foreach (vecs[i]) begin
            mem_we = vecs[i].we; mem_re = vecs[i].re;
            mem_addr = vecs[i].addr; mem_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
            tick();
            mem_we = 1'b0; mem_re = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
            check($sformatf("vec%0d_irq", i), {31'd0, wdt_irq}, {31'd0, vecs[i].exp_irq});
            check($sformatf("vec%0d_reset", i), {31'd0, wdt_reset}, {31'd0, vecs[i].exp_reset});
        end

        // Starvation with IRQ enabled: irq after E17, reset after E25..E28.
        do_reset();
        wr(A_CTRL, 32'h3);
        rd_check("starve_count_e0", A_COUNT, 32'd16);
        for (int k = 1; k <= 29; k++) begin
            tick();
            if (k == 16) rd_check("starve_count_e16", A_COUNT, 32'd0);
            if (k == 16 || k == 17)
                check($sformatf("starve_irq_e%0d", k), {31'd0, wdt_irq}, (k == 17) ? 32'd1 : 32'd0);
            if (k == 24 || k == 25 || k == 28 || k == 29)
                check($sformatf("starve_reset_e%0d", k), {31'd0, wdt_reset},
                      (k >= 25 && k <= 28) ? 32'd1 : 32'd0);
        end
        rd_check("starve_status", A_STATUS, 32'h3);
        rd_check("starve_ctrl", A_CTRL, 32'h2);

        // Regular feeding every 10 cycles.
        do_reset();
        wr(A_CTRL, 32'h3);
        min_cnt = 32'hFFFF_FFFF; irq_seen = 0; rst_seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 10 == 0) wr(A_KICK, KEY);
            else tick();
            rd(A_COUNT, v);
            if (v < min_cnt) min_cnt = v;
            irq_seen |= wdt_irq;
            rst_seen |= wdt_reset;
        end
        check("feed_min_count", min_cnt, 32'd7);
        check("feed_irq_seen", {31'd0, irq_seen}, 32'd0);
        check("feed_reset_seen", {31'd0, rst_seen}, 32'd0);

        // Wrong key escalates immediately.
        do_reset();
        wr(A_CTRL, 32'h3);
        repeat (3) tick();
        wr(A_KICK, BAD_KEY);
        check("badkey_reset_first", {31'd0, wdt_reset}, 32'd1);
        repeat (3) tick();
        check("badkey_reset_last", {31'd0, wdt_reset}, 32'd1);
        tick();
        check("badkey_reset_done", {31'd0, wdt_reset}, 32'd0);
        check("badkey_irq", {31'd0, wdt_irq}, 32'd0);
        rd_check("badkey_status", A_STATUS, 32'h2);
        rd_check("badkey_ctrl", A_CTRL, 32'h2);

        // Kick during grace, then clear IRQF.
        do_reset();
        wr(A_CTRL, 32'h3);
        repeat (17) tick();
        check("grace_irq_up", {31'd0, wdt_irq}, 32'd1);
        repeat (2) tick();
        wr(A_KICK, KEY);
        rd_check("grace_kick_count", A_COUNT, 32'd16);
        check("grace_irq_held", {31'd0, wdt_irq}, 32'd1);
        wr(A_STATUS, 32'h1);
        check("grace_irq_cleared", {31'd0, wdt_irq}, 32'd0);
        rd_check("grace_counting", A_COUNT, 32'd15);
        rd_check("grace_status", A_STATUS, 32'd0);
        rst_seen = 0;
        repeat (10) begin tick(); rst_seen |= wdt_reset; end
        check("grace_no_reset", {31'd0, rst_seen}, 32'd0);
        rd_check("grace_count_later", A_COUNT, 32'd5);

        // Valid kick on the exact COUNT==0 edge.
        do_reset();
        wr(A_CTRL, 32'h3);
        repeat (16) tick();
        rd_check("edge_count_zero", A_COUNT, 32'd0);
        wr(A_KICK, KEY);
        rd_check("edge_count_reload", A_COUNT, 32'd16);
        check("edge_irq", {31'd0, wdt_irq}, 32'd0);
        rd_check("edge_status", A_STATUS, 32'd0);

        // W1C of IRQF on the edge it is set: set wins.
        do_reset();
        wr(A_CTRL, 32'h3);
        repeat (16) tick();
        wr(A_STATUS, 32'h3);
        check("w1c_race_irq", {31'd0, wdt_irq}, 32'd1);
        rd_check("w1c_race_status", A_STATUS, 32'h1);

        // LOAD write while counting only affects the next reload.
        do_reset();
        wr(A_CTRL, 32'h3);
        repeat (2) tick();
        wr(A_LOAD, 32'd10);
        rd_check("load_live_count", A_COUNT, 32'd13);
        rd_check("load_live_load", A_LOAD, 32'd10);
        wr(A_KICK, KEY);
        rd_check("load_next_reload", A_COUNT, 32'd10);

        // Disable during grace: back to idle, IRQF kept, no reset.
        do_reset();
        wr(A_CTRL, 32'h3);
        repeat (18) tick();
        wr(A_CTRL, 32'h2);
        rd_check("disable_count", A_COUNT, 32'd16);
        check("disable_irq_kept", {31'd0, wdt_irq}, 32'd1);
        rst_seen = 0;
        repeat (30) begin tick(); rst_seen |= wdt_reset; end
        check("disable_no_reset", {31'd0, rst_seen}, 32'd0);
        rd_check("disable_status", A_STATUS, 32'h1);

        // rst in the middle of the reset pulse.
        do_reset();
        wr(A_CTRL, 32'h3);
        repeat (26) tick();
        check("midrst_pulse_on", {31'd0, wdt_reset}, 32'd1);
        do_reset();
        check("midrst_reset", {31'd0, wdt_reset}, 32'd0);
        check("midrst_irq", {31'd0, wdt_irq}, 32'd0);
        rd_check("midrst_ctrl", A_CTRL, 32'd0);
        rd_check("midrst_count", A_COUNT, 32'd16);
        rd_check("midrst_status", A_STATUS, 32'd0);

`ifdef WDT_LOCK_EN
        // Locked configuration cannot be disabled or reloaded.
        do_reset();
        wr(A_CTRL, 32'h5);
        wr(A_CTRL, 32'h0);
        rd_check("lock_ctrl", A_CTRL, 32'h5);
        wr(A_LOAD, 32'd5);
        rd_check("lock_load", A_LOAD, 32'd16);
        repeat (14) tick();
        check("lock_reset_pre", {31'd0, wdt_reset}, 32'd0);
        tick();
        check("lock_reset_fires", {31'd0, wdt_reset}, 32'd1);
        do_reset();
        rd_check("lock_after_rst", A_CTRL, 32'd0);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            int          r;
            logic        we;
            logic [31:0] a, d;
            r = int'($urandom_range(0, 199));
            we = 0; a = 32'd0; d = 32'd0;
            if (r < 10)      begin we = 1; a = A_KICK;   d = KEY; end
            else if (r < 12) begin we = 1; a = A_KICK;   d = $urandom; end
            else if (r < 22) begin we = 1; a = A_CTRL;   d = $urandom_range(0, 3); end
            else if (r < 32) begin we = 1; a = A_LOAD;   d = $urandom_range(0, 20); end
            else if (r < 42) begin we = 1; a = A_STATUS; d = $urandom_range(0, 3); end
            else if (r < 120) begin
                case ($urandom_range(0, 6))
                    0: a = A_CTRL;
                    1: a = A_LOAD;
                    2: a = A_KICK;
                    3: a = A_COUNT;
                    4: a = A_STATUS;
                    5: a = BASE + 32'h14;
                    default: a = BASE + 32'h6;
                endcase
                rd_check($sformatf("rand%0d_rd_%0h", c, a), a, m_rdata(a));
            end
            if (we && a == A_KICK && d == KEY && r >= 10) d = d ^ 32'h1;
            if (we) wr(a, d);
            else tick();
            model_edge(we, a, d);
            check($sformatf("rand%0d_irq", c), {31'd0, wdt_irq}, {31'd0, m_irqf & m_irq_en});
            check($sformatf("rand%0d_reset", c), {31'd0, wdt_reset}, (m_phase == 3) ? 32'd1 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
